// File: rtl/rsa_modexp.sv
// rsa_modexp: sequential modular exponentiation, base^exp mod N, computed
// LSB-first by square-and-multiply over exactly 2*WIDTH exponent bits.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   one-cycle request strobe, operands sampled with it (IDLE only)
//   in_base    message/cipher word, reduced mod in_mod at capture
//   in_exp     exponent
//   in_mod     modulus N; N=0 yields result 0
//   busy       high from the cycle after acceptance through the out_valid cycle
//   out_valid  one-cycle result strobe
//   out_data   result, forced to 0 when out_valid is low
//
// state | meaning
// IDLE  | waiting for in_valid
// CALC  | one exponent bit per cycle, 2*WIDTH cycles
// DONE  | result presented for one cycle

module rsa_modexp #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [2*WIDTH-1:0] in_base,
    input  logic [2*WIDTH-1:0] in_exp,
    input  logic [2*WIDTH-1:0] in_mod,
    output logic               busy,
    output logic               out_valid,
    output logic [2*WIDTH-1:0] out_data
);

    localparam int DW = 2 * WIDTH;
    localparam int PW = 4 * WIDTH;
    localparam int CW = $clog2(DW);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    state_e          state_q, state_d;
    logic [DW-1:0]   r_mod_q, r_mod_d;
    logic [DW-1:0]   r_exp_q, r_exp_d;
    logic [DW-1:0]   r_b_q, r_b_d;
    logic [DW-1:0]   r_res_q, r_res_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            out_valid_q, out_valid_d;
    logic [DW-1:0]   out_data_q, out_data_d;

    logic [PW-1:0]   prod_mul;
    logic [PW-1:0]   prod_sq;
    logic            last_bit;

    // Reduction with a zero modulus is defined as 0 so N=0 never produces X.
    function automatic logic [DW-1:0] mod_red(input logic [PW-1:0] x,
                                              input logic [DW-1:0] m);
        logic [PW-1:0] mz;
        mz = {{(PW-DW){1'b0}}, m};
        return (m == '0) ? '0 : DW'(x % mz);
    endfunction

    assign prod_mul = {{DW{1'b0}}, r_res_q} * {{DW{1'b0}}, r_b_q};
    assign prod_sq  = {{DW{1'b0}}, r_b_q} * {{DW{1'b0}}, r_b_q};
    assign last_bit = (cnt_q == CW'(DW - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            r_mod_q     <= '0;
            r_exp_q     <= '0;
            r_b_q       <= '0;
            r_res_q     <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            r_mod_q     <= r_mod_d;
            r_exp_q     <= r_exp_d;
            r_b_q       <= r_b_d;
            r_res_q     <= r_res_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = CALC;
            CALC:    if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        r_mod_d = r_mod_q;
        r_exp_d = r_exp_q;
        r_b_d   = r_b_q;
        r_res_d = r_res_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    r_mod_d = in_mod;
                    r_exp_d = in_exp;
                    r_b_d   = mod_red({{DW{1'b0}}, in_base}, in_mod);
                    r_res_d = mod_red(PW'(1), in_mod);
                    cnt_d   = '0;
                end
            end
            CALC: begin
                if (r_exp_q[0]) r_res_d = mod_red(prod_mul, r_mod_q);
                r_b_d   = mod_red(prod_sq, r_mod_q);
                r_exp_d = r_exp_q >> 1;
                cnt_d   = cnt_q + CW'(1);
            end
            default: ;
        endcase
    end

    // Outputs are computed from the next state so they land in flops and
    // line up with the state they describe.
    always_comb begin
        busy_d      = (state_d != IDLE);
        out_valid_d = (state_d == DONE);
        out_data_d  = (state_d == DONE) ? r_res_d : '0;
    end

    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_rsa_modexp.sv
// Bench for rsa_modexp: an operation log (request cycle, expected value,
// abort cycle) drives a per-cycle check of busy/out_valid/out_data; results
// come from a plain repeated-multiplication model of base^exp mod N.
module tb_rsa_modexp;

    localparam int WIDTH = 4;
    localparam int DW    = 2 * WIDTH;
    localparam int LAT   = 2 * WIDTH + 1;
    localparam int NEVER = 32'h7fffffff;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_base = '0;
    logic [DW-1:0] in_exp = '0;
    logic [DW-1:0] in_mod = '0;
    logic          busy;
    logic          out_valid;
    logic [DW-1:0] out_data;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    typedef struct {
        int a;
        int val;
        int kill;
    } op_t;
    op_t ops[$];

    rsa_modexp #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_base   (in_base),
        .in_exp    (in_exp),
        .in_mod    (in_mod),
        .busy      (busy),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int modexp(input int b, input int e, input int m);
        int r;
        if (m == 0) return 0;
        r = 1 % m;
        for (int i = 0; i < e; i++) r = (r * (b % m)) % m;
        return r;
    endfunction

    function automatic int gcd(input int x, input int y);
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic bit model_busy(input int k);
        foreach (ops[i])
            if (ops[i].a + 1 <= k && k <= ops[i].a + LAT && k <= ops[i].kill) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    always @(negedge clk) begin : cmp
        logic eb, ev;
        int   ed;
        if (chk_en) begin
            eb = 1'b0;
            ev = 1'b0;
            ed = 0;
            foreach (ops[i]) begin
                if (ops[i].a + 1 <= cyc && cyc <= ops[i].a + LAT && cyc <= ops[i].kill) begin
                    eb = 1'b1;
                    if (cyc == ops[i].a + LAT) begin
                        ev = 1'b1;
                        ed = ops[i].val;
                    end
                end
            end
            check("busy", {31'b0, busy}, {31'b0, eb});
            check("out_valid", {31'b0, out_valid}, {31'b0, ev});
            check("out_data", {24'b0, out_data}, ed);
            while (ops.size() > 0 && ops[0].a + LAT < cyc) void'(ops.pop_front());
        end
    end

    // Called at posedge+1; drives one cycle of inputs and logs the request if
    // the model says an idle engine will take it.
    task automatic do_cycle(input bit v, input int b, input int e, input int m,
                            output bit acc, output int a);
        in_valid = v;
        in_base  = DW'(b);
        in_exp   = DW'(e);
        in_mod   = DW'(m);
        acc = v && rst_n && !model_busy(cyc);
        a   = cyc;
        if (acc) ops.push_back('{a: cyc, val: modexp(b, e, m), kill: NEVER});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_base  = DW'($urandom);
        in_exp   = DW'($urandom);
        in_mod   = DW'($urandom);
    endtask

    task automatic wait_out(input int a, input int want, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 3 * LAT && !seen; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                seen = 1'b1;
                check({name, "_lat"}, cyc - a, LAT);
                check(name, {24'b0, out_data}, want);
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s: got no out_valid want result %0d", name, want);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input int b, input int e, input int m, input int want, input string name);
        bit acc;
        int a;
        do_cycle(1'b1, b, e, m, acc, a);
        wait_out(a, want, name);
    endtask

    initial begin : watchdog
        #10_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit acc, acc2;
        int a, a2;
        int pr[5] = '{3, 5, 7, 11, 13};
        int p, q, n, phi, e, d, m, ct;

        check("pin_dec", modexp(31, 7, 33), 4);
        check("pin_maxw", modexp(220, 255, 221), 220);
        check("pin_exp0", modexp(5, 0, 33), 1);
        check("pin_mod0", modexp(9, 3, 0), 0);

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(negedge clk);
        check("reset_busy", {31'b0, busy}, 0);
        check("reset_valid", {31'b0, out_valid}, 0);
        check("reset_data", {24'b0, out_data}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op(31, 7, 33, 4, "dec_31");
        run_op(4, 3, 33, 31, "enc_4");
        run_op(31, 7, 33, 4, "dec_rt");
        run_op(5, 0, 33, 1, "exp0");
        run_op(5, 9, 1, 0, "mod1");
        run_op(40, 1, 33, 7, "base_ge_mod");
        run_op(0, 5, 33, 0, "base0");
        run_op(77, 3, 0, 0, "mod0");
        run_op(220, 255, 221, 220, "maxw");

        // Request three cycles into an operation must vanish; one right
        // after out_valid must be taken.
        do_cycle(1'b1, 31, 7, 33, acc, a);
        do_cycle(1'b0, 0, 0, 0, acc2, a2);
        do_cycle(1'b0, 0, 0, 0, acc2, a2);
        do_cycle(1'b1, 2, 5, 33, acc2, a2);
        wait_out(a, 4, "ign_first");
        run_op(2, 5, 33, 32, "after_done");

        // Abort in the fourth CALC cycle.
        do_cycle(1'b1, 31, 7, 33, acc, a);
        while (cyc < a + 4) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        foreach (ops[i]) if (ops[i].kill > cyc) ops[i].kill = cyc;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_busy", {31'b0, busy}, 0);
        check("abort_valid", {31'b0, out_valid}, 0);
        check("abort_data", {24'b0, out_data}, 0);
        @(posedge clk);
        #1;
        repeat (12) begin
            @(posedge clk);
            #1;
        end
        run_op(4, 3, 33, 31, "post_rst");

        for (int t = 0; t < 500; t++) begin
            p = pr[$urandom_range(0, 4)];
            do q = pr[$urandom_range(0, 4)]; while (q == p);
            n   = p * q;
            phi = (p - 1) * (q - 1);
            do e = $urandom_range(2, phi - 1); while (gcd(e, phi) != 1);
            d = 1;
            while ((e * d) % phi != 1) d++;
            m  = $urandom_range(0, n - 1);
            ct = modexp(m, e, n);
            run_op(m, e, n, ct, "rsa_enc");
            run_op(ct, d, n, m, "rsa_dec");
        end

        // Free-running traffic, including requests while busy and odd moduli.
        for (int t = 0; t < 3000; t++) begin
            int mm;
            case ($urandom_range(0, 7))
                0:       mm = 0;
                1:       mm = 1;
                default: mm = $urandom_range(0, 255);
            endcase
            do_cycle($urandom_range(0, 3) == 0, $urandom_range(0, 255),
                     $urandom_range(0, 255), mm, acc, a);
        end
        repeat (2 * LAT) begin
            @(posedge clk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
